// File: rtl/spiker_reader_core_if.sv
// Spike-frame bus between the unwrap layer and the spike reader core.
// Latency: none (wiring only).
// Backpressure: none. The frame is level-based and the consumer samples whenever it likes.
//
// Signals:
//   data_in  : raw spike vector from the register-file unwrap layer (bit i = spike i)
//   data_out : last committed spike frame, always a complete snapshot
// Modports:
//   master : producer/consumer side (drives data_in, observes data_out)
//   slave  : reader core side (observes data_in, drives data_out)
interface spiker_reader_core_if #(
  parameter int N_SPIKES = 784
);
  logic [N_SPIKES-1:0] data_in;
  logic [N_SPIKES-1:0] data_out;

  modport master (
    output data_in,
    input  data_out
  );

  modport slave (
    input  data_in,
    output data_out
  );
endinterface

// File: rtl/spiker_reader_core.sv
// Captures the spike vector when it changes, scans it word by word into a buffer, then publishes it atomically.
// Latency: NW+1 cycles from the capture edge to the data_out update. Minimum frame period is NW+2 cycles.
// Backpressure: none. Changes to data_in during SCAN/COMMIT are deferred, and are picked up by the next IDLE compare.
//
// Ports:
//   clk_i  : single clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : spiker_reader_core_if.slave (data_in in, data_out out)
module spiker_reader_core #(
  parameter int N_SPIKES = 784,
  parameter int WORD_W   = 32
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  spiker_reader_core_if.slave bus
);

  localparam int NW = (N_SPIKES + WORD_W - 1) / WORD_W;
  localparam int WB = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [WB-1:0] W_LAST = WB'(NW - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t              state_q;
  logic [WB-1:0]       w_q;
  logic [N_SPIKES-1:0] frame_q;
  logic [N_SPIKES-1:0] result_q;
  logic [N_SPIKES-1:0] data_out_q;

  assign bus.data_out = data_out_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      w_q        <= '0;
      frame_q    <= '0;
      result_q   <= '0;
      data_out_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // frame_q is the comparison reference. A change that happened while
          // busy therefore shows up here, and a glitch that settled back does not.
          if (bus.data_in != frame_q) begin
            frame_q <= bus.data_in;
            w_q     <= '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          // Bit-wise word select. Every bit knows its own word number, so the
          // partial last word never addresses anything past N_SPIKES-1.
          for (int i = 0; i < N_SPIKES; i++) begin
            if ((i / WORD_W) == int'(w_q)) begin
              result_q[i] <= frame_q[i];
            end
          end
          if (w_q == W_LAST) begin
            state_q <= COMMIT;
          end else begin
            w_q <= w_q + WB'(1);
          end
        end
        COMMIT: begin
          // Single-edge publish, so consumers never see a half-updated frame.
          data_out_q <= result_q;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spiker_reader_core.sv
// Bench for spiker_reader_core. It drives three instances: 784/32 (NW=25), 40/32 (NW=2) and 8/32 (NW=1).
// Each instance has its own behavioural model: a captured frame plus a countdown of NW+1 edges to publish.
// Directed scenarios come first, followed by randomized frame changes.
module tb_spiker_reader_core;

  localparam int MAXW = 784;

  logic clk_i;
  logic rst_ni;

  logic [MAXW-1:0] din  [3];
  logic [MAXW-1:0] mask [3];
  logic [MAXW-1:0] dout [3];

  // reference model state
  logic [MAXW-1:0] m_frame [3];
  logic [MAXW-1:0] m_out   [3];
  int              m_cnt   [3];
  int              m_nw    [3];

  int total;
  int bad;

  spiker_reader_core_if #(.N_SPIKES(784)) if0 ();
  spiker_reader_core_if #(.N_SPIKES(40))  if1 ();
  spiker_reader_core_if #(.N_SPIKES(8))   if2 ();

  assign if0.data_in = din[0][783:0];
  assign if1.data_in = din[1][39:0];
  assign if2.data_in = din[2][7:0];
  assign dout[0] = if0.data_out;
  assign dout[1] = {{(MAXW-40){1'b0}}, if1.data_out};
  assign dout[2] = {{(MAXW-8){1'b0}}, if2.data_out};

  spiker_reader_core #(.N_SPIKES(784), .WORD_W(32)) dut0 (.clk_i(clk_i), .rst_ni(rst_ni), .bus(if0));
  spiker_reader_core #(.N_SPIKES(40),  .WORD_W(32)) dut1 (.clk_i(clk_i), .rst_ni(rst_ni), .bus(if1));
  spiker_reader_core #(.N_SPIKES(8),   .WORD_W(32)) dut2 (.clk_i(clk_i), .rst_ni(rst_ni), .bus(if2));

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check_outs(input string tag);
    for (int k = 0; k < 3; k++) begin
      total++;
      assert (dout[k] === m_out[k]) else begin
        bad++;
        $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, dout[k], m_out[k]);
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_frame[k] = '0;
      m_out[k]   = '0;
      m_cnt[k]   = 0;
    end
  endtask

  // One clock edge. The model consumes the data_in value that was present at the edge.
  task automatic step(input string tag);
    @(posedge clk_i);
    for (int k = 0; k < 3; k++) begin
      if (!rst_ni) begin
        m_frame[k] = '0;
        m_out[k]   = '0;
        m_cnt[k]   = 0;
      end else if (m_cnt[k] == 0) begin
        if (din[k] != m_frame[k]) begin
          m_frame[k] = din[k];
          m_cnt[k]   = m_nw[k] + 1;
        end
      end else begin
        m_cnt[k] = m_cnt[k] - 1;
        if (m_cnt[k] == 0) m_out[k] = m_frame[k];
      end
    end
    #1;
    check_outs(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic set_din(input int k, input logic [MAXW-1:0] v);
    din[k] = v & mask[k];
  endtask

  function automatic logic [MAXW-1:0] rand_vec();
    logic [799:0] t;
    for (int i = 0; i < 25; i++) t[i*32 +: 32] = $urandom;
    return t[MAXW-1:0];
  endfunction

  initial begin
    logic [MAXW-1:0] pat_a [3];
    logic [MAXW-1:0] pat_b [3];
    logic [MAXW-1:0] v;
    total = 0;
    bad   = 0;
    m_nw[0] = 25;
    m_nw[1] = 2;
    m_nw[2] = 1;
    mask[0] = '1;
    mask[1] = {{(MAXW-40){1'b0}}, {40{1'b1}}};
    mask[2] = {{(MAXW-8){1'b0}}, 8'hFF};
    model_reset();

    // reset held with all-ones input: outputs stay zero
    rst_ni = 1'b0;
    for (int k = 0; k < 3; k++) set_din(k, '1);
    #1;
    check_outs("reset_hold");
    run(3, "reset_hold_clk");

    // release reset: all-ones published after NW+1 edges, zero before
    #2 rst_ni = 1'b1;
    run(30, "reset_release_frame");

    // single frame with sparse pattern
    v = '0;
    v[0] = 1'b1;
    v[783] = 1'b1;
    v[40:33] = 8'hFF;
    set_din(0, v);
    v = '0;
    v[39] = 1'b1;
    v[32] = 1'b1;
    set_din(1, v);
    set_din(2, {{(MAXW-8){1'b0}}, 8'h81});
    run(30, "single_frame");

    // change during scan: A captured, B applied mid-scan, picked up after commit
    for (int k = 0; k < 3; k++) begin
      pat_a[k] = rand_vec();
      pat_a[k][7:0] = 8'hA5;
      pat_a[k] = pat_a[k] & mask[k];
    end
    pat_b[0] = '0;
    pat_b[0][500] = 1'b1;
    pat_b[1] = '0;
    pat_b[1][35] = 1'b1;
    pat_b[2] = {{(MAXW-8){1'b0}}, 8'h10};
    for (int k = 0; k < 3; k++) set_din(k, pat_a[k]);
    run(10, "change_scan_a");
    for (int k = 0; k < 3; k++) set_din(k, pat_b[k]);
    run(60, "change_scan_b");

    // glitch: A captured, B pulsed and restored during scan -> only A published
    for (int k = 0; k < 3; k++) set_din(k, pat_a[k]);
    run(1, "glitch_capture");
    for (int k = 0; k < 3; k++) set_din(k, pat_b[k]);
    run(3, "glitch_pulse");
    for (int k = 0; k < 3; k++) set_din(k, pat_a[k]);
    run(40, "glitch_settle");

    // reset mid-operation: output clears asynchronously, recaptures after release
    for (int k = 0; k < 3; k++) set_din(k, rand_vec() | {{(MAXW-1){1'b0}}, 1'b1});
    run(15, "mid_reset_pre");
    rst_ni = 1'b0;
    model_reset();
    #1;
    check_outs("mid_reset_async");
    run(2, "mid_reset_hold");
    #2 rst_ni = 1'b1;
    run(30, "mid_reset_recapture");

    // randomized changes at random spacing, including reverting to old values
    for (int it = 0; it < 300; it++) begin
      for (int k = 0; k < 3; k++) begin
        case ($urandom_range(0, 7))
          0: set_din(k, rand_vec());
          1: set_din(k, m_frame[k]);
          2: begin
            v = din[k];
            v[$urandom_range(0, MAXW-1)] ^= 1'b1;
            set_din(k, v);
          end
          default: ;
        endcase
      end
      step("random");
    end
    run(30, "random_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spiker_reader_core.md
# spiker_reader_core

Spike-frame reader between the register-file unwrap layer and downstream spiking logic. It captures the flat `N_SPIKES`-bit spike vector whenever it changes and scans it into an internal result buffer in fixed-width words. It then publishes the whole frame atomically on `data_out`. Consumers therefore never see a partially updated spike vector.

## Interface
- `N_SPIKES`, default 784: number of spike lines, and the width of the input and output vectors. Must be ≥1.
- `WORD_W`, default 32: scan word width in bits per cycle. Must be ≥1.
- Derived: `NW = ceil(N_SPIKES / WORD_W)`, which is 25 for the defaults.
- `clk_i`, input, 1 bit: single clock, rising edge.
- `rst_ni`, input, 1 bit: reset, asynchronous and active-low.
- `data_in`, input, `N_SPIKES` bits: spike vector; bit i is spike i.
- `data_out`, output, `N_SPIKES` bits: last committed spike frame; bit i is spike i.

## Operation
- Internal registers:
  - `frame_q` (`N_SPIKES` bits): captured snapshot.
  - `result_q` (`N_SPIKES` bits): scan buffer.
  - `data_out` register.
  - Word index `w`: `$clog2(NW)` bits, minimum 1.
  - FSM state.
- FSM states: IDLE, SCAN, COMMIT.
- IDLE:
  - If `data_in != frame_q`: `frame_q <= data_in`, `w <= 0`, go to SCAN.
  - Otherwise stay in IDLE.
- SCAN:
  - Each cycle, `result_q[w*WORD_W +: WORD_W] <= frame_q` word `w`.
  - The last word is partial when `N_SPIKES % WORD_W != 0`. Only its `N_SPIKES - (NW-1)*WORD_W` valid bits are written; nothing outside `[N_SPIKES-1:0]` is addressed.
  - If `w == NW-1`, go to COMMIT. Otherwise `w <= w+1`.
- COMMIT: `data_out <= result_q`, go to IDLE.
- `data_in` is ignored during SCAN and COMMIT. A change during that window is detected in IDLE after COMMIT, because IDLE compares against `frame_q`.
- If `data_in` returns to the captured value before IDLE, no new frame is started.
- The bit mapping is identity: after commit, `data_out[i] == frame_q[i]` for all i.
- `NW == 1` (`N_SPIKES ≤ WORD_W`): SCAN lasts exactly one cycle.

## Timing
- Reset (asynchronous assert, synchronous release by the clock domain): state IDLE, `w` 0, and `frame_q`, `result_q`, `data_out` all 0.
- An all-zero `data_in` after reset therefore triggers no frame.
- Let capture edge E0 be the IDLE edge where `data_in != frame_q`.
- Edges E1 through E_NW write words 0 through NW-1.
- Edge E_(NW+1) updates `data_out`.
- Latency from capture edge to `data_out` update is NW+1 cycles, i.e. 26 for the defaults.
- `data_out` changes on exactly one edge per frame, with all bits updated together. It holds its value between commits.
- Earliest next capture is E_(NW+2), one IDLE cycle after COMMIT.
- Minimum frame period: NW+2 cycles.
- Reset mid-SCAN or mid-COMMIT: the frame is aborted and `data_out` is cleared to 0 immediately (asynchronously).
- After reset release, the current `data_in` is captured on the first edge if it is nonzero.

## Test plan
- **Reset:** hold `rst_ni`=0 with `data_in` = all ones → `data_out` = 0 and state IDLE.
  - Release reset → `data_out` = all ones after exactly 26 cycles, with no intermediate values.
- **Single frame, defaults:** `data_in` = bit 0 | bit 783 | bits [40:33] set, held constant → `data_out` equals `data_in` at edge E26 and is 0 on every earlier edge.
- **Change during scan:** capture pattern A = `0x...A5` (low byte 0xA5), then switch `data_in` to pattern B = bit 500 only at E10 →
  - `data_out` = A at E26.
  - New capture of B at E27.
  - `data_out` = B at E53.
- **Glitch ignored:** capture A; during SCAN pulse `data_in` to B, then back to A before COMMIT → `data_out` = A at E26 and no further frame.
- **Partial last word:** `N_SPIKES`=40, `WORD_W`=32 (NW=2), `data_in` = bits 39 and 32 set → `data_out` = same at E3, with no out-of-range write.
  - Also `N_SPIKES`=8: latency is 2 cycles.
- **Reset mid-operation:** assert `rst_ni` at E15 of a frame → `data_out` = 0 immediately.
  - After release with `data_in` unchanged and nonzero, `data_out` equals `data_in` 26 cycles after the first edge.
